// File: rtl/shift_sub_divider.sv
// Sequential signed divider: restoring shift-subtract, one quotient bit per cycle,
// with independent valid/ready operand streams and a registered result stream.
module shift_sub_divider #(
  parameter int unsigned WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 tvalid_slave_1,
  input  logic [WIDTH-1:0]     tdata_slave_1,
  output logic                 tready_slave_1,
  input  logic                 tvalid_slave_2,
  input  logic [WIDTH-1:0]     tdata_slave_2,
  output logic                 tready_slave_2,
  output logic                 tvalid_master,
  output logic [2*WIDTH-1:0]   tdata_master,
  output logic                 tuser_master,
  input  logic                 tready_master
);

  localparam int unsigned CW = $clog2(WIDTH);

  typedef enum logic [2:0] {S_INPUT, S_PREP, S_CALC, S_FIX, S_OUTPUT} state_t;

  state_t           state, state_nxt;
  logic             received_1, received_2;
  logic [WIDTH-1:0] dividend_reg, divisor_reg;
  logic [WIDTH-1:0] mag_dividend, mag_divisor, quot;
  logic [WIDTH:0]   prem;
  logic [CW-1:0]    count;
  logic             neg_dividend, neg_quot;

  logic [WIDTH-1:0] abs_dividend, abs_divisor, quot_res, rem_res;
  logic [WIDTH+1:0] diff;
  logic             div_zero;

  assign tready_slave_1 = !received_1 && !reset;
  assign tready_slave_2 = !received_2 && !reset;

  // Magnitudes; the most negative value maps to 2^(WIDTH-1), which fits unsigned.
  assign abs_dividend = dividend_reg[WIDTH-1] ? -dividend_reg : dividend_reg;
  assign abs_divisor  = divisor_reg[WIDTH-1]  ? -divisor_reg  : divisor_reg;

  // Trial subtraction of the divisor from the remainder with the next dividend bit shifted in.
  assign diff = {prem, mag_dividend[WIDTH-1]} - {2'b00, mag_divisor};

  assign quot_res = neg_quot     ? -quot          : quot;
  assign rem_res  = neg_dividend ? -prem[WIDTH-1:0] : prem[WIDTH-1:0];
  assign div_zero = (divisor_reg == '0);

  always_ff @(posedge clk) begin
    if (reset) state <= S_INPUT;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_INPUT:  if (received_1 && received_2) state_nxt = S_PREP;
      S_PREP:   state_nxt = S_CALC;
      S_CALC:   if (count == CW'(WIDTH-1)) state_nxt = S_FIX;
      S_FIX:    state_nxt = S_OUTPUT;
      S_OUTPUT: if (tready_master) state_nxt = S_INPUT;
      default:  state_nxt = S_INPUT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      received_1    <= 1'b0;
      received_2    <= 1'b0;
      dividend_reg  <= '0;
      divisor_reg   <= '0;
      mag_dividend  <= '0;
      mag_divisor   <= '0;
      quot          <= '0;
      prem          <= '0;
      count         <= '0;
      neg_dividend  <= 1'b0;
      neg_quot      <= 1'b0;
      tvalid_master <= 1'b0;
      tdata_master  <= '0;
      tuser_master  <= 1'b0;
    end else begin
      if (tvalid_slave_1 && tready_slave_1) begin
        dividend_reg <= tdata_slave_1;
        received_1   <= 1'b1;
      end
      if (tvalid_slave_2 && tready_slave_2) begin
        divisor_reg <= tdata_slave_2;
        received_2  <= 1'b1;
      end
      case (state)
        S_PREP: begin
          mag_dividend <= abs_dividend;
          mag_divisor  <= abs_divisor;
          neg_dividend <= dividend_reg[WIDTH-1];
          neg_quot     <= dividend_reg[WIDTH-1] ^ divisor_reg[WIDTH-1];
          quot         <= '0;
          prem         <= '0;
          count        <= '0;
        end
        S_CALC: begin
          mag_dividend <= {mag_dividend[WIDTH-2:0], 1'b0};
          prem         <= diff[WIDTH+1] ? {prem[WIDTH-1:0], mag_dividend[WIDTH-1]} : diff[WIDTH:0];
          quot         <= {quot[WIDTH-2:0], ~diff[WIDTH+1]};
          count        <= count + CW'(1);
        end
        S_FIX: begin
          tdata_master  <= div_zero ? {dividend_reg, {WIDTH{1'b1}}} : {rem_res, quot_res};
          tuser_master  <= div_zero;
          tvalid_master <= 1'b1;
        end
        S_OUTPUT: begin
          if (tready_master) begin
            tvalid_master <= 1'b0;
            received_1    <= 1'b0;
            received_2    <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
